// File: rtl/scfifo_stream_reader_pkg.sv
// Shared types and helpers for the single-clock FIFO stream adapters.
package scfifo_pkg;

   localparam int DW_DEF     = 8;
   localparam int RD_LAT_DEF = 1;

   typedef logic [DW_DEF-1:0] dw_t;

   // Bits needed to count from 0 up to and including depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/scfifo_stream_reader_circ_buf.sv
// Small circular buffer with occupancy count and a register-based read-out.
// The head word is presented continuously; pop is ignored while empty.
module stream_circ_buf
   import scfifo_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = 3,
   localparam int CW   = cnt_width(DEPTH),
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] data,
   output logic [CW-1:0] cnt
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop = pop && (cnt != '0);
   assign data   = mem[head];

   // Pointers wrap at DEPTH, which need not be a power of two; count tracks push minus pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            tail <= wrap_inc(tail);
         end
         if (do_pop) begin
            head <= wrap_inc(head);
         end
         case ({push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= push_data;
      end
   end

endmodule

// File: rtl/scfifo_stream_reader.sv
// Read-side adapter: issues FIFO reads against a credit that includes words
// still in the RAM read pipeline, then serves buffered words as a valid/ready stream.
module scfifo_stream_reader
   import scfifo_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int RD_LAT  = RD_LAT_DEF,
   localparam int BUF_DEPTH = RD_LAT + 2,
   localparam int CW        = cnt_width(RD_LAT + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   output logic          fifo_read,
   input  logic [DW-1:0] fifo_dout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] buf_cnt
);

   logic [RD_LAT-1:0] vld;
   logic [CW-1:0]     inflight;
   logic [CW:0]       credit_used;
   logic              push;

   // Count reads still travelling through the RAM latency.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(vld[i]);
      end
   end

   assign credit_used = {1'b0, inflight} + {1'b0, buf_cnt};
   assign fifo_read   = !rst && !fifo_empty && (credit_used < (CW+1)'(BUF_DEPTH));
   assign push        = vld[RD_LAT-1];
   assign out_valid   = (buf_cnt != '0);

   // Valid marker follows each read so fifo_dout is captured exactly when it lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld[0] <= fifo_read;
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   stream_circ_buf #(
      .DW    (DW),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (fifo_dout),
      .pop       (out_ready),
      .data      (out_data),
      .cnt       (buf_cnt)
   );

   // The credit check should make overfilling the buffer impossible.
   always @(posedge clk) begin
      if (!rst) begin
         assert (buf_cnt <= CW'(BUF_DEPTH));
      end
   end

endmodule

// File: tb/tb_scfifo_stream_reader.sv
// Bench for scfifo_stream_reader: one instance at RD_LAT=1 and one at RD_LAT=3
// share a word stream; each has its own FIFO read pointer and latency pipe.
module tb_scfifo_stream_reader;

   localparam int NWORDS = 10000;
   localparam int MEMSZ  = 16384;
   localparam int HIST   = 65536;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       wr_en     = 1'b0;
   logic [7:0] wr_data   = '0;
   logic       out_ready = 1'b0;
   logic       stall_src = 1'b1;

   logic [1:0] fifo_empty;
   logic [1:0] fifo_read;
   logic [1:0] out_valid;
   logic [7:0] fifo_dout [2];
   logic [7:0] out_data  [2];
   logic [1:0] cnt1;
   logic [2:0] cnt3;
   logic [3:0] buf_obs   [2];

   logic [7:0] fmem [MEMSZ];
   logic [7:0] pipe [2][4];
   int         wr_idx = 0;
   int         rd_idx [2];
   int         cyc    = 0;

   int checks   = 0;
   int failures = 0;

   int iss_run   [2];
   int delivered [2];
   int exp_idx   [2];
   int iss_cum   [2][HIST];
   int rst_cyc   = 0;

   logic       rd_tr [6];
   logic       vl_tr [6];
   logic [7:0] dt_tr [6];
   logic [7:0] w     [10];
   logic [7:0] hs    [2];
   int         max_cnt, nreads, got, hs0, written;
   int         run [2];
   int         best [2];
   int         total [2];

   always #5 clk = ~clk;

   scfifo_stream_reader #(.DW(8), .RD_LAT(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty[0]),
      .fifo_read  (fifo_read[0]),
      .fifo_dout  (fifo_dout[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready),
      .out_data   (out_data[0]),
      .buf_cnt    (cnt1)
   );

   scfifo_stream_reader #(.DW(8), .RD_LAT(3)) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty[1]),
      .fifo_read  (fifo_read[1]),
      .fifo_dout  (fifo_dout[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready),
      .out_data   (out_data[1]),
      .buf_cnt    (cnt3)
   );

   assign buf_obs[0]    = {2'b00, cnt1};
   assign buf_obs[1]    = {1'b0, cnt3};
   assign fifo_empty[0] = stall_src || (rd_idx[0] == wr_idx);
   assign fifo_empty[1] = stall_src || (rd_idx[1] == wr_idx);
   assign fifo_dout[0]  = pipe[0][0];
   assign fifo_dout[1]  = pipe[1][2];

   // FIFO model: shared word store, per-instance read pointer, junk on the data pipe when not reading.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_en) begin
         fmem[wr_idx] <= wr_data;
         wr_idx       <= wr_idx + 1;
      end
      for (int i = 0; i < 2; i++) begin
         if (rst) rd_idx[i] <= wr_idx;
         else if (fifo_read[i]) rd_idx[i] <= rd_idx[i] + 1;
         pipe[i][0] <= fifo_read[i] ? fmem[rd_idx[i]] : 8'($urandom);
         for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Reference: words owed = reads issued - words delivered; a read lands in the buffer RD_LAT+1 cycles later.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int   lat;
         int   depth;
         int   arrived;
         int   exp_buf;
         logic exp_rd;
         lat     = (i == 0) ? 1 : 3;
         depth   = lat + 2;
         arrived = 0;
         if (cyc - lat - 1 >= rst_cyc) arrived = iss_cum[i][cyc-lat-1];
         exp_buf = arrived - delivered[i];
         exp_rd  = !rst && !fifo_empty[i] && ((iss_run[i] - delivered[i]) < depth);
         checkOutput("buf_cnt", 32'(buf_obs[i]), 32'(exp_buf));
         checkOutput("out_valid", 32'(out_valid[i]), 32'(exp_buf != 0));
         checkOutput("buf_bound", 32'(int'(buf_obs[i]) <= depth), 32'(1));
         checkOutput("fifo_read", 32'(fifo_read[i]), 32'(exp_rd));
         if (out_valid[i] && exp_buf != 0)
            checkOutput("out_data", 32'(out_data[i]), 32'(fmem[exp_idx[i]]));
         if (rst) begin
            iss_run[i]   = 0;
            delivered[i] = 0;
            exp_idx[i]   = wr_idx;
         end else begin
            if (fifo_read[i]) iss_run[i]++;
            if (out_valid[i] && out_ready) begin
               delivered[i]++;
               exp_idx[i]++;
            end
         end
         if (cyc < HIST) iss_cum[i][cyc] = iss_run[i];
      end
      if (rst) rst_cyc = cyc + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w_en, input logic [7:0] d, input logic rdy, input logic stl);
      wr_en     = w_en;
      wr_data   = d;
      out_ready = rdy;
      stall_src = stl;
   endtask

   task automatic write_word(input logic [7:0] d);
      applyStimulus(1'b1, d, out_ready, stall_src);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      out_ready = 1'b1;
      stall_src = 1'b0;
      while ((exp_idx[0] != wr_idx || exp_idx[1] != wr_idx) && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput("drain_lat1", 32'(exp_idx[0]), 32'(wr_idx));
      checkOutput("drain_lat3", 32'(exp_idx[1]), 32'(wr_idx));
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput("reset_valid", 32'(out_valid[i]), 32'(0));
         checkOutput("reset_cnt", 32'(buf_obs[i]), 32'(0));
         checkOutput("reset_read", 32'(fifo_read[i]), 32'(0));
      end
      tick(1);
      rst = 1'b0;

      // Basic three-word transfer, cycle-exact on the RD_LAT=1 instance.
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      max_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rd_tr[k] = fifo_read[0];
         vl_tr[k] = out_valid[0];
         dt_tr[k] = out_data[0];
         if (int'(buf_obs[0]) > max_cnt) max_cnt = int'(buf_obs[0]);
      end
      for (int k = 0; k < 6; k++) begin
         checkOutput("basic_read", 32'(rd_tr[k]), 32'(k < 3));
         checkOutput("basic_valid", 32'(vl_tr[k]), 32'(k >= 2 && k <= 4));
      end
      checkOutput("basic_data0", 32'(dt_tr[2]), 32'h11);
      checkOutput("basic_data1", 32'(dt_tr[3]), 32'h22);
      checkOutput("basic_data2", 32'(dt_tr[4]), 32'h33);
      checkOutput("basic_maxcnt", 32'(max_cnt), 32'(1));
      tick(8);

      // Back-pressure: consumer stalled, reads must stop at the credit limit.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         w[k] = 8'($urandom);
         write_word(w[k]);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      nreads = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (fifo_read[0]) nreads++;
      end
      checkOutput("bp_reads", 32'(nreads), 32'(3));
      checkOutput("bp_cnt", 32'(buf_obs[0]), 32'(3));
      checkOutput("bp_head", 32'(out_data[0]), 32'(w[0]));
      tick(1);
      drain(80);

      // Sustained throughput: 20 words must leave as one unbroken run.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      for (int k = 0; k < 20; k++) write_word(8'($urandom));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         run[i] = 0; best[i] = 0; total[i] = 0;
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (out_valid[i]) begin
               total[i]++;
               run[i]++;
               if (run[i] > best[i]) best[i] = run[i];
            end else begin
               run[i] = 0;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         checkOutput("tput_total", 32'(total[i]), 32'(20));
         checkOutput("tput_run", 32'(best[i]), 32'(20));
      end
      tick(1);

      // Reset mid-burst: RD_LAT=3 instance holds 2 buffered and 2 in flight.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) write_word(8'(8'h60 + k));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick(4);
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_cnt_before", 32'(buf_obs[1]), 32'(2));
      checkOutput("mid_read_in_rst", 32'(fifo_read[1]), 32'(0));
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput("mid_valid_after", 32'(out_valid[i]), 32'(0));
         checkOutput("mid_cnt_after", 32'(buf_obs[i]), 32'(0));
      end
      tick(1);
      write_word(8'hA0);
      write_word(8'hA1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      hs[0] = '0;
      hs[1] = '0;
      got   = 0;
      for (int n = 0; n < 20 && got < 2; n++) begin
         @(negedge clk);
         if (out_valid[1] && out_ready) begin
            hs[got] = out_data[1];
            got++;
         end
      end
      checkOutput("post_rst_a0", 32'(hs[0]), 32'hA0);
      checkOutput("post_rst_a1", 32'(hs[1]), 32'hA1);
      tick(1);
      drain(40);

      // Pointer wrap: seven words through a three-entry buffer with alternating ready.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) write_word(8'(8'hC0 + k));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      hs0 = 0;
      for (int k = 0; k < 30; k++) begin
         out_ready = (k % 2 == 0);
         @(negedge clk);
         if (out_valid[0] && out_ready) hs0++;
         @(posedge clk);
         #1;
      end
      checkOutput("wrap_count", 32'(hs0), 32'(7));
      drain(20);

      // Random writes and random consumer readiness.
      written = 0;
      for (int n = 0; n < 40000 && written < NWORDS; n++) begin
         applyStimulus(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 1'b0);
         if (wr_en) written++;
         tick(1);
      end
      wr_en = 1'b0;
      drain(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
